// File: rtl/shreg_pkg.sv
// Shared types and helpers for the shift-register serial loader.
// Contents: FSM state encoding, job-type tag, and max_w() for sizing the shared PISO.
package shreg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef enum logic {
        JOB_STAT = 1'b0,
        JOB_DYN  = 1'b1
    } job_t;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/shreg_piso.sv
// Parallel-in/serial-out register with zero fill.
// Ports: clk, rst_n (async, active low), load (captures din), shift (advances one bit),
//        din [W-1:0], ser_out (current serial bit, taken straight from a flop).
// Zero fill means the register drains to all-zero once every loaded bit has been shifted.
module shreg_piso #(
    parameter int unsigned W         = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         ser_out
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_shifted;

    // Next value after one shift in the chosen serial order
    generate
        if (W == 1) begin : g_w1
            assign sr_shifted = '0;
        end else if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr_q[W-2:0], 1'b0};
        end else begin : g_lsb
            assign sr_shifted = {1'b0, sr_q[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= sr_shifted;
        end
    end

    assign ser_out = MSB_FIRST ? sr_q[W-1] : sr_q[0];

endmodule

// File: rtl/shreg_serial_loader.sv
// Serialises static/dynamic configuration words into external shift-register chains.
// Ports: clk, rst_n (async, active low); sel_stat/sel_dyn request strobes with stat_word/dyn_word;
//        sr_data/sr_shift serial interface; sr_latch_stat/sr_latch_dyn chain latch strobes;
//        busy, done (last latch cycle), overrun (sticky dropped-request flag).
module shreg_serial_loader
    import shreg_pkg::*;
#(
    parameter int unsigned STAT_W       = 16,
    parameter int unsigned DYN_W        = 8,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter int unsigned LATCH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel_stat,
    input  logic              sel_dyn,
    input  logic [STAT_W-1:0] stat_word,
    input  logic [DYN_W-1:0]  dyn_word,
    output logic              sr_data,
    output logic              sr_shift,
    output logic              sr_latch_stat,
    output logic              sr_latch_dyn,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int unsigned MAX_W = max_w(STAT_W, DYN_W);
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);
    localparam int unsigned LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    state_t             state_q, state_d;
    job_t               job_q, job_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               pend_valid_q, pend_valid_d;
    job_t               pend_type_q, pend_type_d;
    logic [MAX_W-1:0]   pend_word_q, pend_word_d;
    logic               overrun_d;
    logic               sr_shift_d, latch_stat_d, latch_dyn_d, busy_d, done_d;
    logic               piso_load, piso_shift;
    logic [MAX_W-1:0]   piso_word;
    logic [MAX_W-1:0]   stat_al, dyn_al;

    // Align words so the first serial bit sits where the PISO emits it; unused side is zero
    assign stat_al = MSB_FIRST ? (MAX_W'(stat_word) << (MAX_W - STAT_W)) : MAX_W'(stat_word);
    assign dyn_al  = MSB_FIRST ? (MAX_W'(dyn_word)  << (MAX_W - DYN_W))  : MAX_W'(dyn_word);

    // State, counters, pending slot and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            job_q         <= JOB_STAT;
            bit_cnt_q     <= '0;
            lat_cnt_q     <= '0;
            pend_valid_q  <= 1'b0;
            pend_type_q   <= JOB_STAT;
            pend_word_q   <= '0;
            overrun       <= 1'b0;
            sr_shift      <= 1'b0;
            sr_latch_stat <= 1'b0;
            sr_latch_dyn  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            bit_cnt_q     <= bit_cnt_d;
            lat_cnt_q     <= lat_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_type_q   <= pend_type_d;
            pend_word_q   <= pend_word_d;
            overrun       <= overrun_d;
            sr_shift      <= sr_shift_d;
            sr_latch_stat <= latch_stat_d;
            sr_latch_dyn  <= latch_dyn_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    // Next-state, request arbitration and next output values
    always_comb begin
        state_d      = state_q;
        job_d        = job_q;
        bit_cnt_d    = bit_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        pend_word_d  = pend_word_q;
        overrun_d    = overrun;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_word    = '0;

        // While busy (including the done cycle): other-type request fills an empty slot, else dropped
        if (state_q != IDLE) begin
            if (sel_stat) begin
                if (job_q == JOB_STAT || pend_valid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_type_d  = JOB_STAT;
                    pend_word_d  = stat_al;
                end
            end
            if (sel_dyn) begin
                if (job_q == JOB_DYN || pend_valid_q) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_type_d  = JOB_DYN;
                    pend_word_d  = dyn_al;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (sel_stat) begin
                    state_d   = SHIFT;
                    job_d     = JOB_STAT;
                    bit_cnt_d = CNT_W'(STAT_W);
                    piso_load = 1'b1;
                    piso_word = stat_al;
                    if (sel_dyn) begin
                        pend_valid_d = 1'b1;
                        pend_type_d  = JOB_DYN;
                        pend_word_d  = dyn_al;
                    end
                end else if (sel_dyn) begin
                    state_d   = SHIFT;
                    job_d     = JOB_DYN;
                    bit_cnt_d = CNT_W'(DYN_W);
                    piso_load = 1'b1;
                    piso_word = dyn_al;
                end
            end
            SHIFT: begin
                piso_shift = 1'b1;
                bit_cnt_d  = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_q == CNT_W'(1)) begin
                    state_d   = LATCH;
                    lat_cnt_d = LAT_W'(LATCH_CYCLES - 1);
                end
            end
            LATCH: begin
                if (lat_cnt_q == '0) begin
                    // Pending (possibly captured this very cycle) starts with no IDLE gap
                    if (pend_valid_d) begin
                        state_d      = SHIFT;
                        job_d        = pend_type_d;
                        bit_cnt_d    = (pend_type_d == JOB_STAT) ? CNT_W'(STAT_W) : CNT_W'(DYN_W);
                        piso_load    = 1'b1;
                        piso_word    = pend_word_d;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        sr_shift_d   = (state_d == SHIFT);
        busy_d       = (state_d != IDLE);
        latch_stat_d = (state_d == LATCH) && (job_d == JOB_STAT);
        latch_dyn_d  = (state_d == LATCH) && (job_d == JOB_DYN);
        done_d       = (state_d == LATCH) && (lat_cnt_d == '0);
    end

    shreg_piso #(
        .W         (MAX_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (piso_load),
        .shift   (piso_shift),
        .din     (piso_word),
        .ser_out (sr_data)
    );

endmodule

// File: tb/tb_shreg_serial_loader.sv
module tb_shreg_serial_loader;

    logic        clk;
    logic        rst_n;
    logic        sel_stat, sel_dyn;
    logic [15:0] stat_word;
    logic [7:0]  dyn_word;
    logic        sr_data, sr_shift, sr_latch_stat, sr_latch_dyn, busy, done, overrun;

    logic        sel_stat2, sel_dyn2;
    logic [15:0] stat_word2;
    logic [7:0]  dyn_word2;
    logic        sr_data2, sr_shift2, sr_latch_stat2, sr_latch_dyn2, busy2, done2, overrun2;

    int vectors;
    int miscompares;

    shreg_serial_loader #(
        .STAT_W(16), .DYN_W(8), .MSB_FIRST(1'b1), .LATCH_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sel_stat(sel_stat), .sel_dyn(sel_dyn),
        .stat_word(stat_word), .dyn_word(dyn_word),
        .sr_data(sr_data), .sr_shift(sr_shift),
        .sr_latch_stat(sr_latch_stat), .sr_latch_dyn(sr_latch_dyn),
        .busy(busy), .done(done), .overrun(overrun)
    );

    shreg_serial_loader #(
        .STAT_W(16), .DYN_W(8), .MSB_FIRST(1'b0), .LATCH_CYCLES(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .sel_stat(sel_stat2), .sel_dyn(sel_dyn2),
        .stat_word(stat_word2), .dyn_word(dyn_word2),
        .sr_data(sr_data2), .sr_shift(sr_shift2),
        .sr_latch_stat(sr_latch_stat2), .sr_latch_dyn(sr_latch_dyn2),
        .busy(busy2), .done(done2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    // Output bundle order: {busy, done, overrun, latch_dyn, latch_stat, shift, data}
    function automatic logic [6:0] obs1();
        return {busy, done, overrun, sr_latch_dyn, sr_latch_stat, sr_shift, sr_data};
    endfunction

    function automatic logic [6:0] obs2();
        return {busy2, done2, overrun2, sr_latch_dyn2, sr_latch_stat2, sr_shift2, sr_data2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (obs1() !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_dut got %b want %b", obs1(), 7'b0);
        end
        vectors++;
        if (obs2() !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_dut2 got %b want %b", obs2(), 7'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // A5C3 MSB first, one latch cycle
    task automatic test_static();
        logic       exp_d [16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};
        logic [6:0] e;
        for (int c = 0; c <= 18; c++) begin
            if (c == 0)                 e = 7'b0;
            else if (c <= 16)           e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_d[c-1]};
            else if (c == 17)           e = 7'b1100100;
            else                        e = 7'b0;
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL static c=%0d got %b want %b", c, obs1(), e);
            end
            sel_stat  = (c == 0);
            stat_word = (c == 0) ? 16'hA5C3 : 16'h0000;
            tick();
        end
    endtask

    // Static job at c=0 then dynamic job; optional dropped requests; -1 disables an event
    task automatic two_job_scenario(input string name, input logic [15:0] sw, input logic [7:0] dw,
                                    input int dyn_at, input int drop_stat_at, input int drop_dyn_at,
                                    input int ovr_from);
        logic [6:0] e;
        int         dones;
        dones = 0;
        for (int c = 0; c <= 27; c++) begin
            e[6] = (c >= 1 && c <= 26);
            e[5] = (c == 17 || c == 26);
            e[4] = (ovr_from >= 0 && c >= ovr_from);
            e[3] = (c == 26);
            e[2] = (c == 17);
            e[1] = (c >= 1 && c <= 16) || (c >= 18 && c <= 25);
            e[0] = (c >= 1 && c <= 16) ? sw[16-c] : (c >= 18 && c <= 25) ? dw[25-c] : 1'b0;
            if (done) dones++;
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL %s c=%0d got %b want %b", name, c, obs1(), e);
            end
            sel_stat  = (c == 0) || (c == drop_stat_at);
            stat_word = (c == 0) ? sw : ~sw;
            sel_dyn   = (c == dyn_at) || (c == drop_dyn_at);
            dyn_word  = (c == dyn_at) ? dw : ~dw;
            tick();
        end
        vectors++;
        if (dones !== 2) begin
            miscompares++;
            $display("FAIL %s_done_count got %0d want 2", name, dones);
        end
    endtask

    task automatic test_back_to_back();
        two_job_scenario("back_to_back", 16'hA5C3, 8'h3C, 1, -1, -1, -1);
    endtask

    task automatic test_simultaneous();
        two_job_scenario("simultaneous", 16'h8001, 8'h81, 0, -1, -1, -1);
    endtask

    task automatic test_done_cycle();
        two_job_scenario("done_cycle", 16'h1234, 8'hC9, 17, -1, -1, -1);
    endtask

    task automatic test_overrun();
        two_job_scenario("overrun", 16'hF00F, 8'hAA, 4, 3, 6, 4);
    endtask

    task automatic test_reset_midjob();
        logic       exp_d [8] = '{1,1,0,0,0,1,0,1};
        logic [6:0] e;
        int         latches;
        sel_stat  = 1'b1;
        stat_word = 16'hFFFF;
        tick();
        sel_stat  = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs1() !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_midjob_drop got %b want %b", obs1(), 7'b0);
        end
        latches = 0;
        for (int c = 0; c < 20; c++) begin
            if (sr_latch_stat || sr_latch_dyn) latches++;
            if (c == 3) rst_n = 1'b1;
            tick();
        end
        vectors++;
        if (latches !== 0) begin
            miscompares++;
            $display("FAIL reset_midjob_latch got %0d want 0", latches);
        end
        for (int c = 0; c <= 10; c++) begin
            if (c == 0)       e = 7'b0;
            else if (c <= 8)  e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_d[c-1]};
            else if (c == 9)  e = 7'b1101000;
            else              e = 7'b0;
            vectors++;
            if (obs1() !== e) begin
                miscompares++;
                $display("FAIL after_reset_dyn c=%0d got %b want %b", c, obs1(), e);
            end
            sel_dyn  = (c == 0);
            dyn_word = (c == 0) ? 8'hC5 : 8'h00;
            tick();
        end
    endtask

    // LSB first, three latch cycles, 8'h01
    task automatic test_lsb_latch3();
        logic [6:0] e;
        for (int c = 0; c <= 12; c++) begin
            if (c == 0)       e = 7'b0;
            else if (c == 1)  e = 7'b1000011;
            else if (c <= 8)  e = 7'b1000010;
            else if (c <= 10) e = 7'b1001000;
            else if (c == 11) e = 7'b1101000;
            else              e = 7'b0;
            vectors++;
            if (obs2() !== e) begin
                miscompares++;
                $display("FAIL lsb_latch3 c=%0d got %b want %b", c, obs2(), e);
            end
            sel_dyn2  = (c == 0);
            dyn_word2 = (c == 0) ? 8'h01 : 8'hFE;
            tick();
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b0;
        sel_stat   = 1'b0;
        sel_dyn    = 1'b0;
        stat_word  = '0;
        dyn_word   = '0;
        sel_stat2  = 1'b0;
        sel_dyn2   = 1'b0;
        stat_word2 = '0;
        dyn_word2  = '0;
        vectors     = 0;
        miscompares = 0;

        test_reset();
        test_static();
        test_back_to_back();
        test_simultaneous();
        test_done_cycle();
        test_overrun();
        test_reset_midjob();
        test_lsb_latch3();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
